// File: rtl/light_scene_sequencer_if.sv
// Control and duty/status signals between the lighting sequencer and its environment.
// The slave modport is the sequencer's view of these signals.
interface light_scene_sequencer_if;
   logic        tick;
   logic        start;
   logic        hold;
   logic        override;
   logic [11:0] override_rgb;
   logic [3:0]  red_duty;
   logic [3:0]  green_duty;
   logic [3:0]  blue_duty;
   logic [2:0]  phase;
   logic [7:0]  day_count;

   modport slave (
      input  tick, start, hold, override, override_rgb,
      output red_duty, green_duty, blue_duty, phase, day_count
   );

   modport master (
      output tick, start, hold, override, override_rgb,
      input  red_duty, green_duty, blue_duty, phase, day_count
   );
endinterface

// File: rtl/light_scene_sequencer.sv
// Day/night RGB scene sequencer: ramps 4-bit duties through RISE/DAY/SET/NIGHT on divider
// ticks, with a registered output mux that can substitute manual override duties.
module light_scene_sequencer #(
   parameter int unsigned STEP_TICKS  = 2,
   parameter int unsigned DAY_TICKS   = 8,
   parameter int unsigned NIGHT_TICKS = 4,
   parameter int unsigned NIGHT_BLUE  = 2
) (
   input logic                    CLOCK_50,
   input logic                    reset,
   light_scene_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRise  = 3'd1,
      StDay   = 3'd2,
      StSet   = 3'd3,
      StNight = 3'd4
   } phase_e;

   phase_e      state_q;
   logic [3:0]  red_q, green_q, blue_q;
   logic [3:0]  red_out_q, green_out_q, blue_out_q;
   logic [15:0] step_cnt_q;
   logic [15:0] timer_q;
   logic [7:0]  day_q;

   logic       tick_ok;
   logic       step_due;
   logic [3:0] rise_r, rise_g, rise_b;
   logic [3:0] set_r, set_g, set_b;
   logic       rise_done, set_done;

   // start is handled separately: start==0 overrides everything below reset
   assign tick_ok  = bus.tick & ~bus.hold;
   assign step_due = (step_cnt_q == 16'(STEP_TICKS - 1));

   always_comb begin
      rise_r = (red_q < 4'd15) ? red_q + 4'd1 : red_q;
      rise_g = (red_q >= 4'd8 && green_q < 4'd15) ? green_q + 4'd1 : green_q;
      rise_b = (red_q == 4'd15 && blue_q < 4'd15) ? blue_q + 4'd1 : blue_q;
      set_b  = (blue_q > 4'd0) ? blue_q - 4'd1 : blue_q;
      set_g  = (blue_q <= 4'd7 && green_q > 4'd0) ? green_q - 4'd1 : green_q;
      set_r  = (blue_q == 4'd0 && red_q > 4'd0) ? red_q - 4'd1 : red_q;
      rise_done = &{rise_r, rise_g, rise_b};
      set_done  = ~|{set_r, set_g, set_b};
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         red_q       <= 4'd0;
         green_q     <= 4'd0;
         blue_q      <= 4'd0;
         red_out_q   <= 4'd0;
         green_out_q <= 4'd0;
         blue_out_q  <= 4'd0;
         step_cnt_q  <= 16'd0;
         timer_q     <= 16'd0;
         day_q       <= 8'd0;
      end else begin
         // Output mux samples the pre-edge internal duties, hence one cycle of latency
         if (bus.override) begin
            red_out_q   <= bus.override_rgb[11:8];
            green_out_q <= bus.override_rgb[7:4];
            blue_out_q  <= bus.override_rgb[3:0];
         end else begin
            red_out_q   <= red_q;
            green_out_q <= green_q;
            blue_out_q  <= blue_q;
         end

         if (!bus.start) begin
            state_q    <= StIdle;
            red_q      <= 4'd0;
            green_q    <= 4'd0;
            blue_q     <= 4'd0;
            step_cnt_q <= 16'd0;
            timer_q    <= 16'd0;
         end else begin
            case (state_q)
               StIdle: begin
                  state_q    <= StRise;
                  red_q      <= 4'd0;
                  green_q    <= 4'd0;
                  blue_q     <= 4'd0;
                  step_cnt_q <= 16'd0;
                  timer_q    <= 16'd0;
               end
               StRise: begin
                  if (tick_ok) begin
                     if (step_due) begin
                        step_cnt_q <= 16'd0;
                        red_q      <= rise_r;
                        green_q    <= rise_g;
                        blue_q     <= rise_b;
                        if (rise_done) begin
                           state_q <= StDay;
                           timer_q <= 16'd0;
                        end
                     end else begin
                        step_cnt_q <= step_cnt_q + 16'd1;
                     end
                  end
               end
               StDay: begin
                  if (tick_ok) begin
                     if (timer_q == 16'(DAY_TICKS - 1)) begin
                        state_q    <= StSet;
                        timer_q    <= 16'd0;
                        step_cnt_q <= 16'd0;
                     end else begin
                        timer_q <= timer_q + 16'd1;
                     end
                  end
               end
               StSet: begin
                  if (tick_ok) begin
                     if (step_due) begin
                        step_cnt_q <= 16'd0;
                        red_q      <= set_r;
                        green_q    <= set_g;
                        blue_q     <= set_b;
                        if (set_done) begin
                           state_q <= StNight;
                           timer_q <= 16'd0;
                           blue_q  <= 4'(NIGHT_BLUE);
                        end
                     end else begin
                        step_cnt_q <= step_cnt_q + 16'd1;
                     end
                  end
               end
               StNight: begin
                  if (tick_ok) begin
                     if (timer_q == 16'(NIGHT_TICKS - 1)) begin
                        state_q    <= StRise;
                        timer_q    <= 16'd0;
                        step_cnt_q <= 16'd0;
                        red_q      <= 4'd0;
                        green_q    <= 4'd0;
                        blue_q     <= 4'd0;
                        day_q      <= day_q + 8'd1;
                     end else begin
                        timer_q <= timer_q + 16'd1;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign bus.red_duty   = red_out_q;
   assign bus.green_duty = green_out_q;
   assign bus.blue_duty  = blue_out_q;
   assign bus.phase      = state_q;
   assign bus.day_count  = day_q;

endmodule

// File: tb/tb_light_scene_sequencer.sv
// Directed bench for light_scene_sequencer with STEP_TICKS=2, DAY_TICKS=8, NIGHT_TICKS=4,
// NIGHT_BLUE=2; one full day is 60+8+60+4 = 132 valid ticks.
module tb_light_scene_sequencer;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   light_scene_sequencer_if bus ();

   light_scene_sequencer #(
      .STEP_TICKS (2),
      .DAY_TICKS  (8),
      .NIGHT_TICKS(4),
      .NIGHT_BLUE (2)
   ) u_dut (
      .CLOCK_50(clk),
      .reset   (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input int r, input int g, input int b,
                            input int ph);
      check({tag, ".r"}, 32'(bus.red_duty), r);
      check({tag, ".g"}, 32'(bus.green_duty), g);
      check({tag, ".b"}, 32'(bus.blue_duty), b);
      check({tag, ".phase"}, 32'(bus.phase), ph);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // n consecutive tick cycles, then one idle edge so the output registers catch up
   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         step();
      end
      bus.tick = 1'b0;
      step();
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.tick         = 1'b0;
      bus.start        = 1'b0;
      bus.hold         = 1'b0;
      bus.override     = 1'b0;
      bus.override_rgb = 12'h000;
      #1;
      check_out("reset", 0, 0, 0, 0);
      check("reset.day", 32'(bus.day_count), 0);
      step();
      rst_n = 1'b1;
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      check_out("idle_tick", 0, 0, 0, 0);

      bus.start = 1'b1;
      step();
      check_out("rise_entry", 0, 0, 0, 1);

      run_ticks(30);
      check_out("rise15", 15, 7, 0, 1);

      bus.hold = 1'b1;
      run_ticks(10);
      check_out("hold", 15, 7, 0, 1);
      bus.hold = 1'b0;
      run_ticks(1);
      check_out("hold_rel1", 15, 7, 0, 1);
      run_ticks(1);
      check_out("hold_rel2", 15, 8, 1, 1);

      bus.override     = 1'b1;
      bus.override_rgb = 12'hA5C;
      check_out("ovr_pre", 15, 8, 1, 1);
      step();
      check_out("ovr_on", 10, 5, 12, 1);
      run_ticks(2);
      check_out("ovr_run", 10, 5, 12, 1);
      bus.override = 1'b0;
      step();
      check_out("ovr_rel", 15, 9, 2, 1);

      run_ticks(25);
      check_out("rise29", 15, 15, 14, 1);
      run_ticks(1);
      check_out("day_entry", 15, 15, 15, 2);

      run_ticks(7);
      check_out("day7", 15, 15, 15, 2);
      run_ticks(1);
      check_out("set_entry", 15, 15, 15, 3);
      run_ticks(30);
      check_out("set15", 15, 8, 0, 3);
      run_ticks(29);
      check_out("set29", 1, 0, 0, 3);
      run_ticks(1);
      check_out("night_entry", 0, 0, 2, 4);
      check("night.day", 32'(bus.day_count), 0);

      run_ticks(3);
      check_out("night3", 0, 0, 2, 4);
      run_ticks(1);
      check_out("day1_rise", 0, 0, 0, 1);
      check("day1", 32'(bus.day_count), 1);

      run_ticks(254 * 132);
      check_out("day255_rise", 0, 0, 0, 1);
      check("day255", 32'(bus.day_count), 255);

      run_ticks(63);
      check_out("mid_day", 15, 15, 15, 2);
      bus.start = 1'b0;
      step();
      check("stop.phase", 32'(bus.phase), 0);
      check("stop.day", 32'(bus.day_count), 255);
      step();
      check_out("stop_out", 0, 0, 0, 0);

      bus.start = 1'b1;
      step();
      check_out("restart", 0, 0, 0, 1);
      run_ticks(132);
      check_out("wrap_rise", 0, 0, 0, 1);
      check("wrap.day", 32'(bus.day_count), 0);

      run_ticks(78);
      check_out("mid_set", 15, 15, 10, 3);
      #3;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 0, 0, 0, 0);
      step();
      check_out("rst_held", 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
